dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 19 +
 rtl/rr_arb2.sv | 48 ++++
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared constants for the data-memory arbiter: port indices,
//                byte-lane count and the all-lanes-off write-enable pattern.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_arbiter_pkg;

    // Port indices into the two-bit grant vectors
    localparam int PORT_CPU = 0;
    localparam int PORT_LDR = 1;

    // Byte lanes per data word and the active-low "no lane written" pattern
    localparam int         c_num_lanes = 4;
    localparam logic [3:0] c_lanes_off = 4'hF;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-input round-robin arbiter. Holds the last-grant pointer;
//                the pointer follows the final grant chosen by the parent,
//                which may override the round-robin choice.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic [1:0] i_gnt_taken,
    output logic [1:0] o_gnt
);

    // Index of the port granted most recently; resets to the loader so the
    // CPU wins the first tie after reset.
    logic r_last;

    // Round-robin choice: a lone requester wins, a tie goes to the port not
    // granted last.
    always_comb begin
        o_gnt = i_req;
        if (i_req[PORT_CPU] && i_req[PORT_LDR]) begin
            if (r_last == 1'b1) begin
                o_gnt = 2'b01;
            end else begin
                o_gnt = 2'b10;
            end
        end
    end

    // Pointer moves only on a cycle where some port was actually granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_gnt_taken[PORT_CPU]) begin
            r_last <= 1'b0;
        end else if (i_gnt_taken[PORT_LDR]) begin
            r_last <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port data-memory arbiter. Port 0 is the CPU execute
//                stage, port 1 the loader/debug path. Round-robin on ties,
//                a bounded lock for port 1, single-cycle grant, read data
//                returned one cycle later to the owning port.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 8      // must fit in the 4-bit lock counter
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   p0_req,
    input  logic                   p0_we,
    input  logic [AW-1:0]          p0_addr,
    input  logic [DW-1:0]          p0_wdata,
    input  logic [c_num_lanes-1:0] p0_be,
    input  logic                   p1_req,
    input  logic                   p1_we,
    input  logic [AW-1:0]          p1_addr,
    input  logic [DW-1:0]          p1_wdata,
    input  logic [c_num_lanes-1:0] p1_be,
    input  logic                   p1_lock,
    output logic                   p0_gnt,
    output logic                   p1_gnt,
    output logic                   p0_rvalid,
    output logic                   p1_rvalid,
    output logic [DW-1:0]          rdata,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    output logic [c_num_lanes-1:0] mem_wren_n,
    input  logic [DW-1:0]          mem_rdata
);

    localparam logic [3:0] c_lock_max = 4'(LOCK_MAX);

    logic [3:0] r_lock_cnt;     // consecutive locked port-1 grants while CPU waits
    logic       r_lock_hold;    // port 1 was granted with lock last cycle
    logic       r_tag_valid;    // a read was granted last cycle
    logic       r_tag_port;     // owner of that read

    logic [1:0] w_req;
    logic [1:0] w_rr_gnt;
    logic [1:0] w_gnt;
    logic       w_starve;
    logic       w_rd_issue;

    assign w_req    = {p1_req, p0_req};
    assign w_starve = (r_lock_cnt >= c_lock_max);

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .rst         (rst),
        .i_req       (w_req),
        .i_gnt_taken (w_gnt),
        .o_gnt       (w_rr_gnt)
    );

    // Final grant: starvation relief for the CPU beats the loader lock, which
    // beats plain round-robin. Nothing is granted while reset is asserted.
    always_comb begin
        w_gnt = 2'b00;
        if (!rst) begin
            if (w_starve && p0_req) begin
                w_gnt = 2'b01;
            end else if (r_lock_hold && p1_req) begin
                w_gnt = 2'b10;
            end else begin
                w_gnt = w_rr_gnt;
            end
        end
    end

    assign p0_gnt = w_gnt[PORT_CPU];
    assign p1_gnt = w_gnt[PORT_LDR];

    // Memory-side mux: the granted port drives address/data; idle cycles park
    // the bus at zero with every lane write disabled.
    always_comb begin
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wren_n = c_lanes_off;
        w_rd_issue = 1'b0;
        if (w_gnt[PORT_CPU]) begin
            mem_addr   = p0_addr;
            mem_wdata  = p0_wdata;
            mem_wren_n = p0_we ? ~p0_be : c_lanes_off;
            w_rd_issue = ~p0_we;
        end else if (w_gnt[PORT_LDR]) begin
            mem_addr   = p1_addr;
            mem_wdata  = p1_wdata;
            mem_wren_n = p1_we ? ~p1_be : c_lanes_off;
            w_rd_issue = ~p1_we;
        end
    end

    // Lock bookkeeping: counter clears on any CPU grant or when the loader
    // lets go of lock/req; it only advances while the CPU is being held off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_cnt  <= 4'd0;
            r_lock_hold <= 1'b0;
        end else begin
            r_lock_hold <= w_gnt[PORT_LDR] && p1_lock;
            if (w_gnt[PORT_CPU] || !p1_req || !p1_lock) begin
                r_lock_cnt <= 4'd0;
            end else if (w_gnt[PORT_LDR] && p0_req && (r_lock_cnt != 4'hF)) begin
                r_lock_cnt <= r_lock_cnt + 4'd1;
            end
        end
    end

    // Read-return tag: memory data lands one cycle after the address, so the
    // owner of a granted read is remembered for exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_valid <= 1'b0;
            r_tag_port  <= 1'b0;
        end else begin
            r_tag_valid <= w_rd_issue;
            r_tag_port  <= w_gnt[PORT_LDR];
        end
    end

    assign p0_rvalid = r_tag_valid && (r_tag_port == 1'b0);
    assign p1_rvalid = r_tag_valid && (r_tag_port == 1'b1);
    assign rdata     = r_tag_valid ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter. A ROM-like memory model
//                answers reads one cycle after the address; granted reads are
//                queued with their due cycle and matched against rvalid/rdata.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
    logic [7:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic [3:0]  p0_be, p1_be;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0] rdata;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wren_n;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          due;
    } rd_t;

    rd_t sb[$];
    rd_t mon_e;

    dmem_arbiter #(.AW(8), .DW(32), .LOCK_MAX(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .p0_req     (p0_req),
        .p0_we      (p0_we),
        .p0_addr    (p0_addr),
        .p0_wdata   (p0_wdata),
        .p0_be      (p0_be),
        .p1_req     (p1_req),
        .p1_we      (p1_we),
        .p1_addr    (p1_addr),
        .p1_wdata   (p1_wdata),
        .p1_be      (p1_be),
        .p1_lock    (p1_lock),
        .p0_gnt     (p0_gnt),
        .p1_gnt     (p1_gnt),
        .p0_rvalid  (p0_rvalid),
        .p1_rvalid  (p1_rvalid),
        .rdata      (rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wren_n (mem_wren_n),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents as a pure function of the word address
    function automatic logic [31:0] mem_word(input logic [7:0] a);
        if (a == 8'h05) return 32'hDEADBEEF;
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        mem_rdata <= mem_word(mem_addr);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: every cycle, rvalid/rdata must match the queue head if it is
    // due now, otherwise be idle. Granted reads are queued for the next cycle.
    always @(negedge clk) begin
        check_eq("gnt_exclusive", 32'(p0_gnt & p1_gnt), 32'd0);
        if (rst) begin
            sb.delete();
            check_eq("rst_p0_gnt", 32'(p0_gnt), 32'd0);
            check_eq("rst_p1_gnt", 32'(p1_gnt), 32'd0);
            check_eq("rst_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd0);
            check_eq("rst_rdata", rdata, 32'd0);
            check_eq("rst_wren_n", 32'(mem_wren_n), 32'hF);
        end else begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                check_eq("sb_p0_rvalid", 32'(p0_rvalid), 32'(!mon_e.port));
                check_eq("sb_p1_rvalid", 32'(p1_rvalid), 32'(mon_e.port));
                check_eq("sb_rdata", rdata, mon_e.data);
            end else begin
                check_eq("idle_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd0);
                check_eq("idle_rdata", rdata, 32'd0);
            end
            if (p0_gnt && !p0_we) sb.push_back('{1'b0, mem_word(p0_addr), cyc + 1});
            if (p1_gnt && !p1_we) sb.push_back('{1'b1, mem_word(p1_addr), cyc + 1});
        end
    end

    task automatic drive_p0(input logic req, input logic we, input logic [7:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d; p0_be = be;
    endtask

    task automatic drive_p1(input logic req, input logic we, input logic [7:0] a,
                            input logic [31:0] d, input logic [3:0] be, input logic lock);
        p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d; p1_be = be; p1_lock = lock;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_both();
        drive_p0(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        drive_p1(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic apply_reset();
        next_cycle();
        rst = 1'b1;
        idle_both();
        @(negedge clk);
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_both();
        mem_rdata = 32'h0;

        // Reset: a pending write must not reach memory
        next_cycle();
        drive_p1(1'b1, 1'b1, 8'h44, 32'h11223344, 4'hF, 1'b0);
        @(negedge clk);
        check_eq("reset_p1_gnt", 32'(p1_gnt), 32'd0);
        check_eq("reset_wren_n", 32'(mem_wren_n), 32'hF);
        check_eq("reset_rdata", rdata, 32'd0);

        // First read after reset release
        next_cycle();
        rst = 1'b0;
        drive_p1(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0);
        drive_p0(1'b1, 1'b0, 8'h05, 32'h0, 4'hF);
        @(negedge clk);
        check_eq("rd05_p0_gnt", 32'(p0_gnt), 32'd1);
        check_eq("rd05_mem_addr", 32'(mem_addr), 32'h05);
        check_eq("rd05_wren_n", 32'(mem_wren_n), 32'hF);
        next_cycle();
        idle_both();
        @(negedge clk);
        check_eq("rd05_p0_rvalid", 32'(p0_rvalid), 32'd1);
        check_eq("rd05_rdata", rdata, 32'hDEADBEEF);
        check_eq("idle_mem_addr", 32'(mem_addr), 32'h0);
        check_eq("idle_mem_wdata", mem_wdata, 32'h0);
        check_eq("idle_wren_n", 32'(mem_wren_n), 32'hF);

        // Round-robin with both ports requesting continuously
        apply_reset();
        drive_p0(1'b1, 1'b0, 8'h20, 32'h0, 4'hF);
        drive_p1(1'b1, 1'b0, 8'h30, 32'h0, 4'hF, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("rr_p0_gnt", 32'(p0_gnt), 32'((i % 2) == 0));
            check_eq("rr_p1_gnt", 32'(p1_gnt), 32'((i % 2) == 1));
        end
        next_cycle();
        idle_both();

        // Partial-lane write from port 1, then a zero-lane write from port 0
        next_cycle();
        drive_p1(1'b1, 1'b1, 8'h10, 32'hCAFEF00D, 4'b0011, 1'b0);
        @(negedge clk);
        check_eq("wr_p1_gnt", 32'(p1_gnt), 32'd1);
        check_eq("wr_wren_n", 32'(mem_wren_n), 32'b1100);
        check_eq("wr_mem_addr", 32'(mem_addr), 32'h10);
        check_eq("wr_mem_wdata", mem_wdata, 32'hCAFEF00D);
        next_cycle();
        drive_p1(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0);
        drive_p0(1'b1, 1'b1, 8'h33, 32'h55AA55AA, 4'h0);
        @(negedge clk);
        check_eq("wr0_p0_gnt", 32'(p0_gnt), 32'd1);
        check_eq("wr0_wren_n", 32'(mem_wren_n), 32'hF);
        check_eq("wr0_mem_addr", 32'(mem_addr), 32'h33);
        next_cycle();
        idle_both();

        // Back-to-back reads from different ports
        next_cycle();
        drive_p0(1'b1, 1'b0, 8'h07, 32'h0, 4'hF);
        @(negedge clk);
        check_eq("b2b_p0_gnt", 32'(p0_gnt), 32'd1);
        next_cycle();
        drive_p0(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        drive_p1(1'b1, 1'b0, 8'h08, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        check_eq("b2b_p1_gnt", 32'(p1_gnt), 32'd1);
        check_eq("b2b_p0_rvalid", 32'(p0_rvalid), 32'd1);
        check_eq("b2b_rdata0", rdata, mem_word(8'h07));
        next_cycle();
        idle_both();
        @(negedge clk);
        check_eq("b2b_p1_rvalid", 32'(p1_rvalid), 32'd1);
        check_eq("b2b_rdata1", rdata, mem_word(8'h08));

        // Locked port 1 with the CPU waiting: p0, then 8 x p1, p0, repeating
        apply_reset();
        drive_p0(1'b1, 1'b0, 8'h40, 32'h0, 4'hF);
        drive_p1(1'b1, 1'b0, 8'h50, 32'h0, 4'hF, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("lock_p0_gnt", 32'(p0_gnt), 32'((i == 0) || ((i - 1) % 9 == 8)));
            check_eq("lock_p1_gnt", 32'(p1_gnt), 32'(!((i == 0) || ((i - 1) % 9 == 8))));
        end
        next_cycle();
        idle_both();

        // Lone CPU request right after a locked loader grant is served at once
        next_cycle();
        drive_p1(1'b1, 1'b1, 8'h60, 32'h0, 4'hF, 1'b1);
        @(negedge clk);
        check_eq("lone_p1_gnt", 32'(p1_gnt), 32'd1);
        next_cycle();
        drive_p1(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0);
        drive_p0(1'b1, 1'b1, 8'h61, 32'h0, 4'hF);
        @(negedge clk);
        check_eq("lone_p0_gnt", 32'(p0_gnt), 32'd1);
        next_cycle();
        idle_both();

        // Reset in the cycle after a granted read
        apply_reset();
        drive_p0(1'b1, 1'b0, 8'h09, 32'h0, 4'hF);
        @(negedge clk);
        check_eq("rstrd_p0_gnt", 32'(p0_gnt), 32'd1);
        next_cycle();
        rst = 1'b1;
        drive_p0(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        drive_p1(1'b1, 1'b1, 8'h12, 32'hFFFFFFFF, 4'hF, 1'b0);
        @(negedge clk);
        check_eq("rstrd_p0_rvalid", 32'(p0_rvalid), 32'd0);
        check_eq("rstrd_rdata", rdata, 32'd0);
        check_eq("rstrd_wren_n", 32'(mem_wren_n), 32'hF);
        check_eq("rstrd_p1_gnt", 32'(p1_gnt), 32'd0);
        next_cycle();
        rst = 1'b0;
        drive_p0(1'b1, 1'b0, 8'h0A, 32'h0, 4'hF);
        drive_p1(1'b1, 1'b0, 8'h0B, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        check_eq("rstrd_tie_p0", 32'(p0_gnt), 32'd1);
        check_eq("rstrd_tie_p1", 32'(p1_gnt), 32'd0);
        next_cycle();
        idle_both();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
